// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write arbiter and
// any future scheduler that needs round-robin picking.
package fifo_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int IDX_W = 3;
    localparam int MAX_BURST_LIMIT = 15;
    localparam int CNT_WIDTH = $clog2(MAX_BURST_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit scanning last+1, last+2, ... modulo nreq.
    function automatic pick_t rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input int                  nreq,
        input logic [IDX_W-1:0]    last
    );
        pick_t p;
        int    k;
        p = '0;
        for (int i = 1; i <= MAX_NREQ; i++) begin
            k = (int'(last) + i) % nreq;
            if (i <= nreq && !p.valid && req[k[IDX_W-1:0]]) begin
                p.valid = 1'b1;
                p.idx   = k[IDX_W-1:0];
            end
        end
        return p;
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer and fifo write-side signals of the arbiter.
// master: the arbiter; slave: producers plus fifo.
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);

    logic [NREQ-1:0]        req_i;
    logic [NREQ*DWIDTH-1:0] data_i;
    logic [NREQ-1:0]        last_i;
    logic [NREQ-1:0]        gnt_o;
    logic [NREQ-1:0]        accept_o;
    logic                   flush_req_i;
    logic                   flush_ack_o;
    logic                   fifo_full_i;
    logic                   fifo_write_o;
    logic [DWIDTH-1:0]      fifo_data_o;
    logic                   fifo_flush_o;

    modport master (
        input  req_i,
        input  data_i,
        input  last_i,
        input  flush_req_i,
        input  fifo_full_i,
        output gnt_o,
        output accept_o,
        output flush_ack_o,
        output fifo_write_o,
        output fifo_data_o,
        output fifo_flush_o
    );

    modport slave (
        output req_i,
        output data_i,
        output last_i,
        output flush_req_i,
        output fifo_full_i,
        input  gnt_o,
        input  accept_o,
        input  flush_ack_o,
        input  fifo_write_o,
        input  fifo_data_o,
        input  fifo_flush_o
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester after
// last_owner wins; valid is low when nobody requests.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [MAX_NREQ-1:0] req_x;
    pick_t               pick;

    always_comb begin
        req_x           = '0;
        req_x[NREQ-1:0] = req;
        pick            = rr_pick(req_x, NREQ, last_owner);
    end

    assign winner = pick.idx;
    assign valid  = pick.valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo between NREQ
// producers, with bounded bursts and flush sequencing.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input logic clk,
    input logic rst_n,
    fifo_wr_arbiter_if.master bus
);

    state_t              state;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    last_owner;
    logic [CNT_WIDTH-1:0] cnt;
    logic [NREQ-1:0]     gnt;
    logic                flush_ack;
    logic                fifo_flush;

    logic [MAX_NREQ-1:0] req_x;
    logic [MAX_NREQ-1:0] last_x;
    logic [DWIDTH-1:0]   slice [MAX_NREQ];

    logic                own_req;
    logic                own_last;
    logic [DWIDTH-1:0]   own_data;
    logic                accept;
    logic                burst_end;

    logic [IDX_W-1:0]    win_idx;
    logic                win_valid;

    always_comb begin
        req_x            = '0;
        last_x           = '0;
        req_x[NREQ-1:0]  = bus.req_i;
        last_x[NREQ-1:0] = bus.last_i;
        for (int k = 0; k < MAX_NREQ; k++) begin
            slice[k] = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            slice[k] = bus.data_i[k*DWIDTH +: DWIDTH];
        end
    end

    assign own_req  = req_x[owner];
    assign own_last = last_x[owner];
    assign own_data = slice[owner];

    // Reset also blocks the write so an abandoned burst leaves no word behind.
    assign accept = rst_n
                  & (state == BURST)
                  & own_req
                  & ~bus.fifo_full_i
                  & ~bus.flush_req_i;

    assign burst_end = accept
                     & (own_last
                        | (cnt == CNT_WIDTH'(MAX_BURST - 1)));

    rr_priority_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req        (bus.req_i),
        .last_owner (last_owner),
        .winner     (win_idx),
        .valid      (win_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NREQ - 1);
            cnt        <= '0;
            gnt        <= '0;
            flush_ack  <= 1'b0;
            fifo_flush <= 1'b0;
        end else begin
            flush_ack  <= 1'b0;
            fifo_flush <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.flush_req_i) begin
                        state      <= FLUSH;
                        flush_ack  <= 1'b1;
                        fifo_flush <= 1'b1;
                    end else if (win_valid) begin
                        state <= BURST;
                        owner <= win_idx;
                        gnt   <= NREQ'(onehot(win_idx));
                        cnt   <= '0;
                    end
                end
                BURST: begin
                    if (bus.flush_req_i) begin
                        state      <= FLUSH;
                        last_owner <= owner;
                        gnt        <= '0;
                        flush_ack  <= 1'b1;
                        fifo_flush <= 1'b1;
                    end else if (!own_req || burst_end) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        gnt        <= '0;
                    end else if (accept) begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt_o        = gnt;
    assign bus.accept_o     = accept ? NREQ'(onehot(owner)) : '0;
    assign bus.fifo_write_o = accept;
    assign bus.fifo_data_o  = own_data;
    assign bus.fifo_flush_o = fifo_flush;
    assign bus.flush_ack_o  = flush_ack;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h",
                     name, $time, got, exp);
        end
    endtask

    // Model state: owner<0 means no grant; m_flush marks the flush cycle.
    bit              m_valid = 1'b0;
    int              m_owner = -1;
    bit              m_flush = 1'b0;
    int              m_last  = NREQ - 1;
    int              m_cnt   = 0;
    int              waits [NREQ];
    logic [NREQ-1:0] prev_acc = '0;

    logic [NREQ-1:0]   rq, ls, e_gnt, e_acc;
    logic              fl, fr, e_wr;
    logic [DWIDTH-1:0] e_data;
    int                win;

    always @(negedge clk) begin
        rq    = bus.req_i;
        ls    = bus.last_i;
        fl    = bus.fifo_full_i;
        fr    = bus.flush_req_i;
        e_acc = '0;
        e_wr  = 1'b0;
        if (m_valid) begin
            e_gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
            e_wr  = rst_n && m_owner >= 0 && rq[m_owner] && !fl && !fr;
            e_acc = e_wr ? e_gnt : '0;
            check("gnt", bus.gnt_o, e_gnt);
            check("accept", bus.accept_o, e_acc);
            check("write", bus.fifo_write_o, e_wr);
            check("fifo_flush", bus.fifo_flush_o, m_flush);
            check("flush_ack", bus.flush_ack_o, m_flush);
            if (e_wr) begin
                e_data = bus.data_i[m_owner*DWIDTH +: DWIDTH];
                check("data", bus.fifo_data_o, e_data);
            end
            check("inv_write_and_flush",
                  bus.fifo_write_o & bus.fifo_flush_o, 0);
            check("inv_accept_subset_gnt",
                  |(bus.accept_o & ~bus.gnt_o), 0);
            check("inv_write_when_full",
                  bus.fifo_write_o & bus.fifo_full_i, 0);
        end
        prev_acc = e_acc;

        if (!rst_n) begin
            m_valid = 1'b1;
            m_owner = -1;
            m_flush = 1'b0;
            m_last  = NREQ - 1;
            m_cnt   = 0;
            for (int k = 0; k < NREQ; k++) waits[k] = 0;
        end else if (m_valid) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!rq[k]) waits[k] = 0;
            end
            if (m_flush) begin
                m_flush = 1'b0;
            end else if (m_owner < 0) begin
                if (fr) begin
                    m_flush = 1'b1;
                end else begin
                    win = -1;
                    for (int i = 1; i <= NREQ; i++) begin
                        if (win < 0 && rq[(m_last + i) % NREQ])
                            win = (m_last + i) % NREQ;
                    end
                    if (win >= 0) begin
                        check("fairness_wait", waits[win] <= NREQ - 1, 1);
                        for (int j = 0; j < NREQ; j++) begin
                            if (j != win && rq[j]) waits[j]++;
                        end
                        waits[win] = 0;
                        m_owner    = win;
                        m_cnt      = 0;
                    end
                end
            end else if (fr) begin
                m_last  = m_owner;
                m_owner = -1;
                m_flush = 1'b1;
            end else if (!rq[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (e_wr) begin
                m_cnt++;
                if (ls[m_owner] || m_cnt == MAX_BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string name,
                        input logic [NREQ-1:0] gnt,
                        input logic wr);
        #1;
        check({name, "_gnt"}, bus.gnt_o, gnt);
        check({name, "_write"}, bus.fifo_write_o, wr);
    endtask

    task automatic set_data(input int k, input logic [DWIDTH-1:0] d);
        bus.data_i[k*DWIDTH +: DWIDTH] = d;
    endtask

    logic [DWIDTH-1:0] t1_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        rst_n           = 1'b0;
        bus.req_i       = '0;
        bus.data_i      = '0;
        bus.last_i      = '0;
        bus.flush_req_i = 1'b0;
        bus.fifo_full_i = 1'b0;
        step();
        step();
        #1;
        check("reset_gnt", bus.gnt_o, 0);
        check("reset_write", bus.fifo_write_o, 0);
        check("reset_flush", bus.fifo_flush_o, 0);
        check("reset_ack", bus.flush_ack_o, 0);

        // All requesting, single-word bursts: 0,1,2,3,0.
        rst_n      = 1'b1;
        bus.req_i  = 4'b1111;
        bus.last_i = 4'b1111;
        bus.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int g = 0; g < 5; g++) begin
            step();
            look("rr_grant", NREQ'(1 << (g % 4)), 1'b1);
            check("rr_data", bus.fifo_data_o, t1_data[g]);
            step();
            look("rr_bubble", 4'b0000, 1'b0);
        end
        bus.req_i = '0;

        // Requester 0 alone, no last: MAX_BURST words then re-grant.
        step();
        bus.req_i  = 4'b0001;
        bus.last_i = 4'b0000;
        set_data(0, 8'hA5);
        for (int w = 0; w < MAX_BURST; w++) begin
            step();
            look("max_burst", 4'b0001, 1'b1);
            check("max_burst_data", bus.fifo_data_o, 8'hA5);
        end
        step();
        look("max_burst_idle", 4'b0000, 1'b0);
        step();
        look("max_burst_regrant", 4'b0001, 1'b1);
        step();
        bus.req_i = '0;
        look("abandon", 4'b0001, 1'b0);
        step();
        look("abandon_idle", 4'b0000, 1'b0);

        // Requester 2 stalled by fifo full for 3 cycles.
        bus.req_i = 4'b0100;
        set_data(2, 8'hC3);
        step();
        look("stall_first", 4'b0100, 1'b1);
        step();
        bus.fifo_full_i = 1'b1;
        look("stall", 4'b0100, 1'b0);
        step();
        look("stall", 4'b0100, 1'b0);
        step();
        look("stall", 4'b0100, 1'b0);
        step();
        bus.fifo_full_i = 1'b0;
        for (int w = 0; w < 3; w++) begin
            look("stall_resume", 4'b0100, 1'b1);
            step();
        end
        look("stall_done", 4'b0000, 1'b0);
        bus.req_i = '0;

        // Flush interrupts requester 1 after two words.
        step();
        bus.req_i = 4'b0010;
        set_data(1, 8'h5A);
        step();
        look("pre_flush", 4'b0010, 1'b1);
        step();
        look("pre_flush", 4'b0010, 1'b1);
        step();
        bus.flush_req_i = 1'b1;
        look("flush_req", 4'b0010, 1'b0);
        step();
        bus.flush_req_i = 1'b0;
        bus.req_i       = 4'b0110;
        look("flush_cycle", 4'b0000, 1'b0);
        check("flush_cycle_flush", bus.fifo_flush_o, 1);
        check("flush_cycle_ack", bus.flush_ack_o, 1);
        step();
        look("post_flush_idle", 4'b0000, 1'b0);
        step();
        look("post_flush_grant", 4'b0100, 1'b1);
        step();
        bus.req_i = '0;
        step();
        step();

        // Reset in the middle of a burst.
        bus.req_i = 4'b1000;
        set_data(3, 8'h77);
        step();
        look("pre_reset", 4'b1000, 1'b1);
        step();
        rst_n = 1'b0;
        look("in_reset", 4'b1000, 1'b0);
        step();
        rst_n     = 1'b1;
        bus.req_i = 4'b1001;
        look("after_reset", 4'b0000, 1'b0);
        check("after_reset_flush", bus.fifo_flush_o, 0);
        check("after_reset_ack", bus.flush_ack_o, 0);
        step();
        look("after_reset_grant", 4'b0001, 1'b1);
        step();
        bus.req_i = '0;
        step();
        step();

        // Random traffic; the compare process does the checking.
        for (int c = 0; c < 10000; c++) begin
            step();
            rst_n = ($urandom_range(0, 1999) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.req_i[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req_i[k]  = 1'b1;
                        bus.last_i[k] = ($urandom_range(0, 2) == 0);
                        set_data(k, DWIDTH'($urandom));
                    end
                end else if (prev_acc[k]) begin
                    if (bus.last_i[k] || $urandom_range(0, 3) == 0)
                        bus.req_i[k] = 1'b0;
                    bus.last_i[k] = ($urandom_range(0, 2) == 0);
                    set_data(k, DWIDTH'($urandom));
                end else if ($urandom_range(0, 63) == 0) begin
                    bus.req_i[k] = 1'b0;
                end
            end
            bus.fifo_full_i = ($urandom_range(0, 3) == 0);
            bus.flush_req_i = ($urandom_range(0, 49) == 0);
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo instance (DWIDTH data, full/almost_full/flush interface) among NREQ producers.
- Grants one producer at a time for a bounded burst.
- Muxes the granted producer's data onto the fifo write port and gates writes on fifo full.
- Sequences fifo flushes on request.
- Sits directly in front of the fifo write side; the fifo read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 8, data width; must equal the fifo DWIDTH
MAX_BURST, 4, maximum words accepted per grant (1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
req_i  input  NREQ  per-requester request; bit k held high while requester k has a word on its data slice
data_i  input  NREQ*DWIDTH  requester k data at [k*DWIDTH +: DWIDTH]
last_i  input  NREQ  per-requester end-of-burst marker, qualified with its word
gnt_o  output  NREQ  registered one-hot grant; all-zero when no owner
accept_o  output  NREQ  combinational one-hot: word of requester k is consumed this cycle
flush_req_i  input  1  flush request pulse or level
flush_ack_o  output  1  one-cycle pulse when the fifo flush is issued
fifo_full_i  input  1  from fifo full_o
fifo_write_o  output  1  to fifo write_i
fifo_data_o  output  DWIDTH  to fifo data_i
fifo_flush_o  output  1  to fifo flush_i

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state=IDLE; gnt_o=0; flush_ack_o=0; fifo_flush_o=0; fifo_write_o=0.
  - Burst counter = 0.
  - last_owner = NREQ-1, so requester 0 has the highest priority after reset.
- Reset asserted mid-burst: abandons the burst at that edge; no further writes.
- States: IDLE, BURST, FLUSH (encoded in 2 bits).
- IDLE:
  - If flush_req_i=1, go to FLUSH. Flush beats arbitration.
  - Else if any req_i bit is set, the winner is the first set bit scanning last_owner+1, last_owner+2, ... modulo NREQ. Register owner, set gnt_o to the winner's one-hot, clear the counter, go to BURST.
  - Else stay in IDLE.
- Grant latency: at least 1 cycle from req_i rising to gnt_o. No writes happen in IDLE.
- BURST:
  - accept = req_i[owner] & ~fifo_full_i & ~flush_req_i.
  - accept_o[owner] = accept.
  - fifo_write_o = accept.
  - fifo_data_o = owner data slice (always driven; value is don't-care when fifo_write_o=0).
  - On accept: count+1.
- BURST exit to IDLE at the edge following any of:
  - accept & last_i[owner];
  - accept & count==MAX_BURST-1;
  - req_i[owner]==0 (requester abandoned).
- On BURST exit: last_owner := owner, gnt_o := 0.
- fifo_full_i=1 in BURST: hold the grant and stall with no write; the burst count does not advance.
- flush_req_i=1 in BURST:
  - No write occurs that cycle.
  - Go to FLUSH.
  - last_owner := owner, so the interrupted requester loses priority.
- FLUSH (exactly 1 cycle):
  - fifo_flush_o=1, flush_ack_o=1, gnt_o=0, fifo_write_o=0.
  - Next state is IDLE.
  - A flush_req_i still high in IDLE triggers another flush; the requester must drop it after flush_ack_o.
- Invariants:
  - fifo_write_o and fifo_flush_o are never both 1.
  - accept_o is at most one-hot and is a subset of gnt_o.
  - fifo_write_o=1 implies fifo_full_i=0.
- Fairness: a continuously requesting requester is granted within NREQ-1 intervening bursts.
- Throughput: max MAX_BURST words per grant, plus one IDLE bubble between grants.

Decomposition:
- Package fifo_arb_pkg holds:
  - state typedef (IDLE, BURST, FLUSH);
  - function rr_pick(req, last_owner) returning the winner index and a valid bit;
  - function onehot(idx);
  - constant CNT_WIDTH sized from MAX_BURST.
- One natural sub-module: rr_priority_picker. It is combinational: inputs req and last_owner; outputs winner index and valid. It is reusable by a future read-side scheduler.

Test Plan:
- Reset, then req_i=4'b1111, every last_i=1, fifo_full_i=0 → grants in order 0,1,2,3,0, one word each, with one IDLE cycle between grants; fifo_data_o matches each owner's slice.
- req_i=4'b0001 held, last_i=0, MAX_BURST=4 → exactly 4 consecutive writes of requester 0 data, gnt_o drops, re-grant to 0 after 1 IDLE cycle.
- Requester 2 granted, fifo_full_i=1 for 3 cycles mid-burst → no fifo_write_o during the stall, gnt_o stays 4'b0100, burst resumes and completes the remaining count.
- Requester 1 in BURST after 2 words, flush_req_i pulse → no write that cycle; next cycle fifo_flush_o=flush_ack_o=1, gnt_o=0; next arbitration with req_i=4'b0110 grants requester 2.
- rst_n=0 for 1 cycle during a burst with req_i=4'b1000 → all outputs at reset values next cycle; after rst_n=1 with req_i=4'b1001, requester 0 is granted first.
- Random req_i, last_i, fifo_full_i and flush_req_i for 10k cycles against a reference model → invariants hold; fairness bound of NREQ-1 bursts is met; the written word sequence matches the model.
